// File: rtl/bit_serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder evaluated per clock, LSB first,
// with valid/ready handshakes. Define BIT_SERIAL_ADDER_OVF_EN to add the ovf output.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef BIT_SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);
    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             w_fa_sum;
    logic             w_fa_cout;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_shift;

    full_adder u_fa (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .sum  (w_fa_sum),
        .cout (w_fa_cout)
    );

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_last   = (r_state == S_RUN) && (r_cnt == LAST);

    // Each new bit enters at the MSB, so after WIDTH shifts bit i sits at sum[i].
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign w_sum_shift = w_fa_sum;
        end else begin : g_sum_wn
            assign w_sum_shift = {w_fa_sum, r_sum[WIDTH-1:1]};
        end
    endgenerate

    // NOTE: state and datapath flops use non-blocking assignments so every
    // register samples pre-edge values, whatever order the blocks run in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            S_IDLE:  in_ready  = 1'b1;
            S_RUN:   busy      = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_sum   <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_carry <= w_fa_cout;
            r_cnt   <= r_cnt + CW'(1);
            r_sum   <= w_sum_shift;
            if (w_last) begin
                r_cout <= w_fa_cout;
            end
        end
    end

`ifdef BIT_SERIAL_ADDER_OVF_EN
    logic r_ovf;

    // On the MSB cycle r_carry is the carry into the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= r_carry ^ w_fa_cout;
        end
    end

    assign ovf = r_ovf;
`endif

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed self-checking bench for bit_serial_adder at WIDTH=8; the ovf
// checks are compiled in when BIT_SERIAL_ADDER_OVF_EN is defined.

module tb_bit_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef BIT_SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
`ifdef BIT_SERIAL_ADDER_OVF_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle 1 time unit past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    // One full operation with out_ready held high; must start in IDLE.
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin,
                         output logic [W-1:0] os, output logic oc, output logic oo,
                         output int lat, output bit tmo);
        in_valid  = 1'b1;
        a         = ia;
        b         = ib;
        cin       = icin;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        lat      = 0;
        tmo      = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            lat++;
            if (out_valid === 1'b1) begin
                tmo = 1'b0;
                break;
            end
        end
        os = sum;
        oc = cout;
`ifdef BIT_SERIAL_ADDER_OVF_EN
        oo = ovf;
`else
        oo = 1'b0;
`endif
        tick();
    endtask

    task automatic test_reset();
        logic [W+3:0] obs;
        bit           seen_valid;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        obs = {in_ready, out_valid, busy, cout, sum};
        n_checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_state: {in_ready,out_valid,busy,cout,sum}=%h expected %h", obs, 12'h800);
        end

        // Abort an operation part way through RUN.
        in_valid = 1'b1;
        a        = 8'hAA;
        b        = 8'h55;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_accept_busy: busy=%b expected 1", busy);
        end
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        obs = {in_ready, out_valid, busy, cout, sum};
        n_checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_mid_run: {in_ready,out_valid,busy,cout,sum}=%h expected %h", obs, 12'h800);
        end
        seen_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid !== 1'b0) seen_valid = 1'b1;
        end
        n_checks++;
        if (seen_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_no_result: out_valid_seen=%b in_ready=%b expected 0/1", seen_valid, in_ready);
        end
    endtask

    task automatic test_zero_latency();
        int  busy_cycles;
        int  lat;
        bit  tmo;
        in_valid  = 1'b1;
        a         = 8'h00;
        b         = 8'h00;
        cin       = 1'b0;
        out_ready = 1'b0;
        tick();
        in_valid    = 1'b0;
        busy_cycles = 0;
        lat         = 0;
        tmo         = 1'b1;
        if (busy === 1'b1) busy_cycles++;
        for (int i = 0; i < 40; i++) begin
            tick();
            lat++;
            if (out_valid === 1'b1) begin
                tmo = 1'b0;
                break;
            end
            if (busy === 1'b1) busy_cycles++;
        end
        n_checks++;
        if (tmo !== 1'b0 || lat != W) begin
            n_fail++;
            $display("FAIL zero_latency: timeout=%b latency=%0d expected 0/%0d", tmo, lat, W);
        end
        n_checks++;
        if (busy_cycles != W || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_busy: busy_cycles=%0d busy_in_done=%b expected %0d/0", busy_cycles, busy, W);
        end
        n_checks++;
        if (sum !== 8'h00 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_result: sum=%h cout=%b expected 00/0", sum, cout);
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_release: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_carry_ripple();
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           lat;
        bit           tmo;
        do_op(8'hFF, 8'h01, 1'b0, s, c, o, lat, tmo);
        n_checks++;
        if (tmo !== 1'b0 || s !== 8'h00 || c !== 1'b1) begin
            n_fail++;
            $display("FAIL ripple_ff_01: timeout=%b sum=%h cout=%b expected 0/00/1", tmo, s, c);
        end
        do_op(8'hA5, 8'h5A, 1'b1, s, c, o, lat, tmo);
        n_checks++;
        if (tmo !== 1'b0 || s !== 8'h00 || c !== 1'b1) begin
            n_fail++;
            $display("FAIL ripple_a5_5a_c1: timeout=%b sum=%h cout=%b expected 0/00/1", tmo, s, c);
        end
        do_op(8'h3C, 8'h47, 1'b1, s, c, o, lat, tmo);
        n_checks++;
        if (tmo !== 1'b0 || s !== 8'h84 || c !== 1'b0) begin
            n_fail++;
            $display("FAIL mixed_3c_47_c1: timeout=%b sum=%h cout=%b expected 0/84/0", tmo, s, c);
        end
    endtask

    task automatic test_backpressure();
        bit tmo;
        bit held_ok;
        in_valid  = 1'b1;
        a         = 8'h12;
        b         = 8'h34;
        cin       = 1'b0;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tmo      = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid === 1'b1) begin
                tmo = 1'b0;
                break;
            end
        end
        n_checks++;
        if (tmo !== 1'b0 || sum !== 8'h46 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_result: timeout=%b sum=%h cout=%b expected 0/46/0", tmo, sum, cout);
        end
        // A new operand pair offered during DONE must be ignored.
        in_valid = 1'b1;
        a        = 8'hFF;
        b        = 8'hFF;
        cin      = 1'b1;
        held_ok  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 ||
                sum !== 8'h46 || cout !== 1'b0) held_ok = 1'b0;
        end
        n_checks++;
        if (held_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold: held=%b out_valid=%b in_ready=%b sum=%h expected 1/1/0/46", held_ok, out_valid, in_ready, sum);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 8'h46 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b sum=%h cout=%b expected 0/1/46/0", out_valid, in_ready, sum, cout);
        end
    endtask

    task automatic test_back_to_back();
        int k1;
        int k2;
        bit tmo;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 8'h01;
        b         = 8'h01;
        cin       = 1'b0;
        tick();
        k1 = cycle;
        // Present the second pair immediately; it must wait for IDLE.
        a   = 8'h80;
        b   = 8'h7F;
        cin = 1'b1;
        tmo = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid === 1'b1) begin
                tmo = 1'b0;
                break;
            end
        end
        n_checks++;
        if (tmo !== 1'b0 || sum !== 8'h02 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first: timeout=%b sum=%h cout=%b expected 0/02/0", tmo, sum, cout);
        end
        tick();
        tick();
        k2       = cycle;
        in_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || (k2 - k1) != W + 2) begin
            n_fail++;
            $display("FAIL b2b_interval: busy=%b accept_gap=%0d expected 1/%0d", busy, k2 - k1, W + 2);
        end
        tmo = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid === 1'b1) begin
                tmo = 1'b0;
                break;
            end
        end
        n_checks++;
        if (tmo !== 1'b0 || sum !== 8'h00 || cout !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: timeout=%b sum=%h cout=%b expected 0/00/1", tmo, sum, cout);
        end
        tick();
    endtask

`ifdef BIT_SERIAL_ADDER_OVF_EN
    task automatic test_ovf();
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           lat;
        bit           tmo;
        do_op(8'h7F, 8'h01, 1'b0, s, c, o, lat, tmo);
        n_checks++;
        if (tmo !== 1'b0 || s !== 8'h80 || c !== 1'b0 || o !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_7f_01: sum=%h cout=%b ovf=%b expected 80/0/1", s, c, o);
        end
        do_op(8'h80, 8'h80, 1'b0, s, c, o, lat, tmo);
        n_checks++;
        if (tmo !== 1'b0 || s !== 8'h00 || c !== 1'b1 || o !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_80_80: sum=%h cout=%b ovf=%b expected 00/1/1", s, c, o);
        end
        do_op(8'hFF, 8'h01, 1'b0, s, c, o, lat, tmo);
        n_checks++;
        if (tmo !== 1'b0 || s !== 8'h00 || c !== 1'b1 || o !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_ff_01: sum=%h cout=%b ovf=%b expected 00/1/0", s, c, o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_zero_latency();
        test_carry_ripple();
        test_backpressure();
        test_back_to_back();
`ifdef BIT_SERIAL_ADDER_OVF_EN
        test_ovf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_serial_adder.md
# bit_serial_adder

Multi-cycle WIDTH-bit adder that processes one bit per clock through a single `full_adder` instance. A registered carry feeds each result bit's carry-out back as the next bit's `cin`. It accepts a parallel operand pair via a valid/ready handshake, shifts operands LSB-first, and collects the serial sum into a parallel result register. It sits directly upstream of and around `full_adder`: it drives the adder's `a`/`b`/`cin` each cycle and consumes its `sum`/`cout`. It is the area-minimal adder option for wide datapaths.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range 1 to 64.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand pair on `a`, `b`, `cin` is valid.
- `in_ready`  out  1  block can accept operands; high only in IDLE.
- `a`  in  WIDTH  operand A, unsigned or two's complement.
- `b`  in  WIDTH  operand B.
- `cin`  in  1  initial carry-in.
- `out_valid`  out  1  `sum` and `cout` are valid; high only in DONE.
- `out_ready`  in  1  consumer accepts the result.
- `sum`  out  WIDTH  registered result, a+b+cin mod 2^WIDTH.
- `cout`  out  1  carry out of the MSB.
- `busy`  out  1  high in RUN.

## Operation
- FSM has three states: IDLE, RUN, DONE. It resets to IDLE.
- IDLE:
  - The block drives `in_ready=1`.
  - On `in_valid && in_ready` it loads `a` and `b` into shift registers and `cin` into the carry flop.
  - It clears the bit counter and the sum register, then moves to RUN.
- RUN, every cycle:
  - `full_adder` inputs are `a_sr[0]`, `b_sr[0]`, `carry_q`.
  - Its `sum` shifts into the sum register MSB-side, filling toward the LSB so that bit i ends at `sum[i]`.
  - Its `cout` is registered into `carry_q`.
  - Both operand shift registers shift right by 1, and the counter increments.
  - When the counter reaches WIDTH-1 on this edge, the block latches `cout` from `carry_q`'s next value and moves to DONE.
- DONE:
  - `out_valid=1`; `sum` and `cout` are held stable.
  - On `out_ready` the block returns to IDLE. Result registers keep their values; only `out_valid` drops.
- Arithmetic: {cout,sum} = a + b + cin exactly. The result is identical for signed and unsigned operands.
- The counter is `$clog2(WIDTH+1)` bits wide. With WIDTH=1, RUN lasts exactly one cycle.
- `in_valid` outside IDLE is ignored, and input values are don't-care outside the accept edge.
- `out_ready` outside DONE is ignored.
- Reset at any time, including mid-RUN or during DONE, aborts the operation immediately.
  - State returns to IDLE.
  - All registers clear to 0.
  - No partial result is ever presented.

## Timing
- Reset values: `in_ready=1`, `out_valid=0`, `busy=0`, `sum=0`, `cout=0`, plus `ovf=0` if enabled.
- Accept edge k: `busy=1` from k. Bits 0 to WIDTH-1 are processed on edges k+1 to k+WIDTH.
- `out_valid` rises after edge k+WIDTH, so latency is WIDTH cycles from the accept edge.
- With `out_ready` held high, `out_valid` is high for exactly one cycle and drops after edge k+WIDTH+1. `in_ready` returns on that same edge.
- Minimum initiation interval is WIDTH+2 cycles; there is no overlap of consecutive operations.
- Backpressure: `out_valid`, `sum` and `cout` are held for as many cycles as `out_ready` stays low, and `in_ready` stays 0 throughout.
- All outputs are registered or decoded from FSM state only. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `BIT_SERIAL_ADDER_OVF_EN`.
- Defined:
  - Adds output `ovf  out  1`: signed overflow, equal to (carry into MSB) XOR `cout`.
  - `ovf` is latched on the MSB cycle, valid with `out_valid`, and held with `sum`.
  - Reset value is 0.
- Undefined: the `ovf` port and its logic are absent, and all other behaviour is unchanged.

## Test plan
- Reset mid-RUN: accept 0xAA+0x55 (WIDTH=8), assert `rst` for one cycle 3 cycles later. Required: all outputs at reset values, `in_ready=1`, and no `out_valid` ever appears for that operation.
- Zero/latency: 0x00+0x00, cin=0 accepted at edge k. Required: `out_valid` first high after edge k+8, `sum=0x00`, `cout=0`, `busy` high for exactly 8 cycles.
- Carry ripple: 0xFF+0x01, cin=0 gives `sum=0x00`, `cout=1`. 0xA5+0x5A, cin=1 gives `sum=0x00`, `cout=1`.
- Backpressure: 0x12+0x34, cin=0, with `out_ready=0` for 5 cycles after `out_valid`. Required: `sum=0x46` and `cout=0` stable, `in_ready=0`, and a concurrently asserted `in_valid` is ignored. Result accepted on the first edge with `out_ready=1`.
- Back-to-back with `out_ready`=1 throughout: 0x01+0x01, then 0x80+0x7F, cin=1. Required: results 0x02/0, then 0x00/1, with acceptance edges exactly 10 cycles apart.
- With `BIT_SERIAL_ADDER_OVF_EN`: 0x7F+0x01 gives 0x80, `cout=0`, `ovf=1`. 0x80+0x80 gives 0x00, `cout=1`, `ovf=1`. 0xFF+0x01 gives `ovf=0`.
